// File: rtl/projectile_hit_ctl_if.sv
// VGA timing/pixel bundle shared by the draw chain stages.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport vga_in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport vga_out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/projectile_hit_ctl.sv
// Dog-side ballistic projectile: per-frame flight update, cat hit / miss detection,
// and a one-clock overlay of the projectile square onto the VGA stream.
module projectile_hit_ctl #(
  parameter int          CAT_X     = 1,
  parameter int          CAT_Y     = 430,
  parameter int          CAT_W     = 157,
  parameter int          CAT_H     = 99,
  parameter int          START_X   = 860,
  parameter int          START_Y   = 430,
  parameter int          PROJ_SIZE = 8,
  parameter int          GROUND_Y  = 560,
  parameter int          GRAVITY   = 1,
  parameter logic [11:0] PROJ_RGB  = 12'h840
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fire,
  input  logic [5:0]  vx_in,
  input  logic [5:0]  vy_in,
  vga_if.vga_in       vga_in,
  vga_if.vga_out      vga_out,
  output logic        hit_cat,
  output logic        miss,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_CHECK} state_t;

  state_t             r_state, w_next;
  logic [10:0]        r_px;
  logic signed [11:0] r_py;
  logic signed [7:0]  r_vy;
  logic [5:0]         r_vx;
  logic               r_edge;
  logic               r_vsync_q;
  logic               r_hit, r_miss;

  logic w_tick, w_load, w_step, w_hit, w_miss;
  logic w_overlap, w_ground, w_px_lt_vx, w_in_box;
  int   w_px_i, w_py_i, w_hc, w_vc;

  assign w_tick = vga_in.vsync & ~r_vsync_q;

  // Integer views keep the signed y / unsigned x comparisons free of width surprises.
  assign w_px_i = int'(r_px);
  assign w_py_i = int'(r_py);
  assign w_hc   = int'(vga_in.hcount);
  assign w_vc   = int'(vga_in.vcount);

  assign w_px_lt_vx = w_px_i < int'(r_vx);
  assign w_overlap  = (w_px_i < CAT_X + CAT_W) && (w_px_i + PROJ_SIZE > CAT_X) &&
                      (w_py_i < CAT_Y + CAT_H) && (w_py_i + PROJ_SIZE > CAT_Y);
  assign w_ground   = (w_py_i + PROJ_SIZE >= GROUND_Y);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_hit  = 1'b0;
    w_miss = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fire) begin
          w_load = 1'b1;
          w_next = S_FLY;
        end
      end
      S_FLY: begin
        if (w_tick) begin
          w_step = ~w_px_lt_vx;
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_overlap) begin
          w_hit  = 1'b1;
          w_next = S_IDLE;
        end else if (r_edge || w_ground) begin
          w_miss = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_next = S_FLY;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_px      <= '0;
      r_py      <= '0;
      r_vy      <= '0;
      r_vx      <= '0;
      r_edge    <= 1'b0;
      r_vsync_q <= 1'b0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
    end else begin
      r_vsync_q <= vga_in.vsync;
      r_hit     <= w_hit;
      r_miss    <= w_miss;
      if (w_load) begin
        r_px   <= 11'(START_X);
        r_py   <= 12'(START_Y);
        r_vy   <= 8'd0 - {2'b00, vy_in};
        r_vx   <= vx_in;
        r_edge <= 1'b0;
      end else if (r_state == S_FLY && w_tick) begin
        r_edge <= w_px_lt_vx;
        if (w_step) begin
          // Position uses the old vy; gravity lands on vy afterwards.
          r_px <= r_px - 11'(r_vx);
          r_py <= r_py + 12'(r_vy);
          r_vy <= r_vy + 8'(GRAVITY);
        end
      end
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign hit_cat = r_hit;
  assign miss    = r_miss;

  assign w_in_box = busy && !vga_in.hblnk && !vga_in.vblnk && (w_py_i >= 0) &&
                    (w_hc >= w_px_i) && (w_hc < w_px_i + PROJ_SIZE) &&
                    (w_vc >= w_py_i) && (w_vc < w_py_i + PROJ_SIZE);

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.vcount <= '0;
      vga_out.vsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.vcount <= vga_in.vcount;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.vblnk  <= vga_in.vblnk;
      vga_out.hcount <= vga_in.hcount;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.rgb    <= w_in_box ? PROJ_RGB : vga_in.rgb;
    end
  end

endmodule
